// File: rtl/ttl_pkg.sv
// ttl_pkg: mode-select encodings shared by the 74194 universal shift register.
package ttl_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;
endpackage

// File: rtl/ttl_edge_qual.sv
// ttl_edge_qual: qualifies Chip_clk into an advance strobe for the Clk domain.
// TTL_74194_EDGE_DET_EN selects rising-edge detection; otherwise Chip_clk is a level enable.
module ttl_edge_qual (
    input  logic Clk,
    input  logic Reset,
    input  logic Chip_clk,
    output logic adv_q
);
`ifdef TTL_74194_EDGE_DET_EN
    logic prev_q;
    // Reset primes prev high so a Chip_clk held high through reset is not seen as an edge.
    always_ff @(posedge Clk)
        prev_q <= Reset ? 1'b1 : Chip_clk;
    assign adv_q = Chip_clk & ~prev_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = Clk ^ Reset;
    assign adv_q = Chip_clk;
`endif
endmodule

// File: rtl/ttl_74194_universal.sv
// ttl_74194_universal: 74194-style universal shift register clocked by an emulated TTL clock.
// Define TTL_74194_EDGE_DET_EN to advance only on Chip_clk rising edges.
module ttl_74194_universal
    import ttl_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Chip_clk,
    input  logic             Clear_bar,
    input  logic             Preset_bar,
    input  logic [1:0]       S,
    input  logic             Dsr,
    input  logic             Dsl,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             Adv
);
    logic             adv;
    logic [WIDTH-1:0] q_q, q_d, mode_val;
    logic             adv_q, adv_d;
    mode_e            mode;

    ttl_edge_qual u_qual (
        .Clk      (Clk),
        .Reset    (Reset),
        .Chip_clk (Chip_clk),
        .adv_q    (adv)
    );

    assign mode = mode_e'(S);

    always_comb begin
        mode_val = mode == MODE_SHR  ? {q_q[WIDTH-2:0], Dsr} :
                   mode == MODE_SHL  ? {Dsl, q_q[WIDTH-1:1]} :
                   mode == MODE_LOAD ? D : q_q;
        q_d      = !Clear_bar  ? '0 :
                   !Preset_bar ? '1 :
                   adv         ? mode_val : q_q;
        adv_d    = adv & Clear_bar & Preset_bar;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q   <= INIT;
            adv_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            adv_q <= adv_d;
        end
    end

    assign Q     = q_q;
    assign Q_bar = ~q_q;
    assign Adv   = adv_q;
endmodule

// File: tb/tb_ttl_74194_universal.sv
// tb_ttl_74194_universal: directed vectors with a queue scoreboard for ttl_74194_universal.
module tb_ttl_74194_universal;
    localparam bit EDGE =
`ifdef TTL_74194_EDGE_DET_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [3:0] q;
        logic       adv;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1, cc = 1'b0, clr = 1'b1, pre = 1'b1;
    logic [1:0] s = 2'b00;
    logic       dsr = 1'b0, dsl = 1'b0;
    logic [3:0] d = 4'h0;
    logic [3:0] q, q_bar;
    logic       adv;
    exp_t       sb[$];
    int         passed = 0, total = 0;
    bit         done = 1'b0;

    ttl_74194_universal #(.WIDTH(4), .INIT(4'h0)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Chip_clk   (cc),
        .Clear_bar  (clr),
        .Preset_bar (pre),
        .S          (s),
        .Dsr        (dsr),
        .Dsl        (dsl),
        .D          (d),
        .Q          (q),
        .Q_bar      (q_bar),
        .Adv        (adv)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, c, cl, pr, input logic [1:0] sv, input logic sr, sl,
                       input logic [3:0] dv, eq, input logic ea, input string nm);
        exp_t e;
        rst = r; cc = c; clr = cl; pre = pr; s = sv; dsr = sr; dsl = sl; d = dv;
        @(posedge clk);
        e.q = eq; e.adv = ea; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    // Monitor: every Clk edge yields one registered output sample to score.
    initial begin
        exp_t e;
        while (!done || sb.size() != 0) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.name, ".Q"}, q, e.q);
                chk({e.name, ".Q_bar"}, q_bar, ~e.q);
                chk({e.name, ".Adv"}, {3'b0, adv}, {3'b0, e.adv});
            end
        end
    end

    initial begin
        // rst cc clr pre S dsr dsl D | expected Q, Adv
        cyc(1, 1, 1, 1, 2'b11, 0, 0, 4'hA, 4'h0, 0, "reset_cc_high");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'hA, EDGE ? 4'h0 : 4'hA, !EDGE, "release_hold1");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'hA, EDGE ? 4'h0 : 4'hA, !EDGE, "release_hold2");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'hA, EDGE ? 4'h0 : 4'hA, 0, "cc_low");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'hA, 4'hA, 1, "load_A");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'hA, 4'hA, 0, "load_A_idle");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'h1, 4'h1, 1, "load_1");
        cyc(0, 0, 1, 1, 2'b01, 1, 0, 4'h0, 4'h1, 0, "load_1_idle");
        cyc(0, 1, 1, 1, 2'b01, 1, 0, 4'h0, 4'h3, 1, "shr1");
        cyc(0, 0, 1, 1, 2'b01, 1, 0, 4'h0, 4'h3, 0, "shr1_idle");
        cyc(0, 1, 1, 1, 2'b01, 1, 0, 4'h0, 4'h7, 1, "shr2");
        cyc(0, 0, 1, 1, 2'b01, 1, 0, 4'h0, 4'h7, 0, "shr2_idle");
        cyc(0, 1, 1, 1, 2'b01, 1, 0, 4'h0, 4'hF, 1, "shr3");
        cyc(0, 0, 1, 1, 2'b10, 0, 0, 4'h0, 4'hF, 0, "shr3_idle");
        cyc(0, 1, 1, 1, 2'b10, 0, 0, 4'h0, 4'h7, 1, "shl1");
        cyc(0, 0, 1, 1, 2'b10, 0, 0, 4'h0, 4'h7, 0, "shl1_idle");
        cyc(0, 1, 1, 1, 2'b10, 0, 0, 4'h0, 4'h3, 1, "shl2");
        cyc(0, 0, 1, 1, 2'b10, 0, 0, 4'h0, 4'h3, 0, "shl2_idle");
        cyc(0, 1, 1, 1, 2'b10, 0, 0, 4'h0, 4'h1, 1, "shl3");
        cyc(0, 0, 1, 1, 2'b10, 0, 0, 4'h0, 4'h1, 0, "shl3_idle");
        cyc(0, 1, 1, 1, 2'b10, 0, 0, 4'h0, 4'h0, 1, "shl4");
        cyc(0, 0, 1, 1, 2'b00, 0, 0, 4'h0, 4'h0, 0, "shl4_idle");
        cyc(0, 1, 1, 1, 2'b00, 0, 0, 4'h5, 4'h0, 1, "hold_adv");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'h6, 4'h0, 0, "hold_idle");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'h6, 4'h6, 1, "load_6");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'h6, 4'h6, 0, "load_6_idle");
        cyc(0, 1, 0, 0, 2'b11, 0, 0, 4'h9, 4'h0, 0, "clr_pre_wins");
        cyc(0, 0, 1, 0, 2'b11, 0, 0, 4'h9, 4'hF, 0, "preset");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'h9, 4'hF, 0, "preset_release");
        cyc(0, 0, 0, 1, 2'b11, 0, 0, 4'h9, 4'h0, 0, "clear_no_adv");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'h3, 4'h0, 0, "pre_held");
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'h3, 4'h3, !EDGE || i == 0, $sformatf("held_cc%0d", i));
        cyc(1, 1, 1, 1, 2'b01, 1, 0, 4'h3, 4'h0, 0, "reset_mid_shift");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'h5, EDGE ? 4'h0 : 4'h5, !EDGE, "post_reset1");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'h5, EDGE ? 4'h0 : 4'h5, !EDGE, "post_reset2");
        cyc(0, 0, 1, 1, 2'b11, 0, 0, 4'h5, EDGE ? 4'h0 : 4'h5, 0, "post_reset_low");
        cyc(0, 1, 1, 1, 2'b11, 0, 0, 4'h5, 4'h5, 1, "post_reset_rise");
        done = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ttl_74194_universal.md
TTL_74194_UNIVERSAL -- requirements
Module: ttl_74194_universal

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (2..32).
REQ-002 SHALL have parameter INIT, default 0, WIDTH-bit value loaded into Q by Reset.
REQ-003 SHALL have input Clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have input Reset, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have input Chip_clk, 1 bit: emulated TTL clock, qualified per REQ-020/REQ-021.
REQ-006 SHALL have input Clear_bar, 1 bit: active-low clear of all bits.
REQ-007 SHALL have input Preset_bar, 1 bit: active-low set of all bits.
REQ-008 SHALL have input S, 2 bits: mode select.
REQ-009 SHALL have input Dsr, 1 bit: serial data for shift-right.
REQ-010 SHALL have input Dsl, 1 bit: serial data for shift-left.
REQ-011 SHALL have input D, WIDTH bits: parallel load data.
REQ-012 SHALL have output Q, WIDTH bits: register contents (Q[0] = stage A).
REQ-013 SHALL have output Q_bar, WIDTH bits: always ~Q.
REQ-014 SHALL have output Adv, 1 bit: high for the one Clk cycle after a qualified advance.

Function
REQ-015 SHALL, on a qualified advance, act on S: 00 hold; 01 shift right (Q[0]<=Dsr, Q[i]<=Q[i-1]); 10 shift left (Q[WIDTH-1]<=Dsl, Q[i]<=Q[i+1]); 11 load (Q<=D).
REQ-016 SHALL apply priority per Clk edge: Reset > Clear_bar low > Preset_bar low > qualified advance > hold.
REQ-017 SHALL make Clear_bar and Preset_bar take effect on the next Clk edge whether or not an advance is qualified.
REQ-018 SHALL, with Clear_bar and Preset_bar both low, give Q = 0 (clear wins).
REQ-019 SHALL keep Q unchanged on any Clk edge with no qualified advance and no clear/preset/reset.
REQ-020 SHALL, with TTL_74194_EDGE_DET_EN undefined, treat every Clk edge with Chip_clk=1 as a qualified advance.
REQ-021 SHALL, with TTL_74194_EDGE_DET_EN defined, qualify an advance only on a Clk edge where Chip_clk=1 and its registered previous sample is 0, so Q updates on that same edge.
REQ-022 SHALL set Adv to 1 on the edge a qualified advance is taken, whatever S is, and clear it on the next edge with no advance. Adv SHALL be 0 if clear, preset or reset overrides the advance.
REQ-023 SHALL have no combinational path from inputs to Q or Adv.

Reset
REQ-024 SHALL on Reset set Q=INIT, Adv=0, and the Chip_clk previous-sample register to 1, so a Chip_clk held high through reset causes no advance.
REQ-025 SHALL, when Reset is asserted mid-shift, discard any advance that is pending that cycle.

Configuration
REQ-026 SHALL use macro TTL_74194_EDGE_DET_EN. Defined: rising-edge detection on Chip_clk per REQ-021. Undefined: level clock-enable per REQ-020, and the previous-sample register is not built.

Structure
REQ-027 SHALL take the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD from shared package ttl_pkg.
REQ-028 SHALL place the qualification logic in sub-module ttl_edge_qual (inputs Clk, Reset, Chip_clk; output adv_q), compiled per REQ-026.

Verification (WIDTH=4, INIT=4'h0)
REQ-029 SHALL check load: S=11, D=4'hA, one qualified advance -> Q=4'hA, Q_bar=4'h5, Adv=1 for one cycle.
REQ-030 SHALL check shift-right: Q=4'h1, S=01, Dsr=1, three advances -> Q=4'hF. Then S=10, Dsl=0, four advances -> Q=4'h0.
REQ-031 SHALL check priority: Q=4'h6, Clear_bar=0, Preset_bar=0, S=11, D=4'h9, advance -> Q=4'h0, Adv=0. Then Clear_bar=1 -> Q=4'hF on the next Clk.
REQ-032 SHALL check edge mode with macro defined: Chip_clk held 1 for 5 Clk cycles, S=11, D=4'h3 -> exactly one load and one Adv pulse. With macro undefined -> Adv=1 on all 5 cycles.
REQ-033 SHALL check reset: Reset=1 while Chip_clk=1 and S=11 -> Q=INIT and Adv=0. Release with Chip_clk still 1 (macro defined) -> no advance until Chip_clk falls and rises again.
